// File: rtl/dvi_timing_pkg.sv
// dvi_timing_pkg
//   Shared types and timing constant sets for the DVI timing generator.
//   - state_t           : IDLE / RUN
//   - VGA_*             : 640x480@60 (25.2 MHz pixel clock), negative syncs
//   - SVGA_*            : 800x600@60 (40 MHz pixel clock), positive syncs
//   - h_total / v_total : total pixels per line / lines per frame
package dvi_timing_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam bit VGA_HS_POL   = 1'b0;
    localparam bit VGA_VS_POL   = 1'b0;

    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;
    localparam bit SVGA_HS_POL   = 1'b1;
    localparam bit SVGA_VS_POL   = 1'b1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/dvi_timing_gen_sig_delay_line.sv
// sig_delay_line
//   Fixed-depth shift register that re-times the stage-0 sync/DE flags so
//   they line up with pixel data returned D cycles after the request.
//   Ports:
//     clk25_2 : pixel clock
//     reset_n : asynchronous active-low reset, loads INIT into every stage
//     din     : W-bit stage-0 value
//     dout    : din delayed by D cycles
module sig_delay_line #(
    parameter int             W    = 4,
    parameter int             D    = 2,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic         clk25_2,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] stage [D];

    always_ff @(posedge clk25_2 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < D; i++) begin
                stage[i] <= INIT;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < D; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[D-1];

endmodule

// File: rtl/dvi_timing_gen.sv
// dvi_timing_gen
//   Parametrised video timing generator for the CH7301C DVI path. Walks an
//   (x,y) raster, requests pixels from the upstream source and emits
//   DE/HSYNC/VSYNC/VBLANK delayed by PIPE_DEPTH so they match the returned
//   pixel data. Start/stop requests are honoured only at frame boundaries.
//   Ports:
//     clk25_2     : pixel clock
//     reset_n     : asynchronous active-low reset
//     enable      : run request, sampled at frame end (and in IDLE)
//     pix_req     : pixel (pix_x,pix_y) wanted, data due PIPE_DEPTH later
//     pix_x/pix_y : raster counters
//     frame_start : pulse at (0,0) while running
//     line_start  : pulse at x=0 on active lines
//     dvi_de      : delayed data enable
//     dvi_hs/vs   : delayed syncs at HS_POL/VS_POL active level
//     vblank      : delayed, high on lines >= V_ACTIVE
//     running     : FSM is in RUN
//
//   state | meaning
//   IDLE  | counters parked at (0,0), no requests, delay line drains
//   RUN   | raster advancing; leaves only after the last pixel of a frame
module dvi_timing_gen
    import dvi_timing_pkg::*;
#(
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit HS_POL     = VGA_HS_POL,
    parameter bit VS_POL     = VGA_VS_POL,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 12
) (
    input  logic             clk25_2,
    input  logic             reset_n,
    input  logic             enable,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start,
    output logic             line_start,
    output logic             dvi_de,
    output logic             dvi_hs,
    output logic             dvi_vs,
    output logic             vblank,
    output logic             running
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if ((H_TOTAL > (2 ** CNT_W)) || (V_TOTAL > (2 ** CNT_W)) || (PIPE_DEPTH < 1)) begin : g_param_check
        $error("dvi_timing_gen: totals exceed counter range or PIPE_DEPTH < 1");
    end

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);

    // Boundaries held at 32 bits: the sync end can equal 2**CNT_W and
    // would alias to zero at counter width.
    localparam int unsigned X_ACT  = H_ACTIVE;
    localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
    localparam int unsigned HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned Y_ACT  = V_ACTIVE;
    localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
    localparam int unsigned VS_END = V_ACTIVE + V_FP + V_SYNC;

    // Delay line carries {de, hs level, vs level, vblank}.
    localparam logic [3:0] DL_INIT = {1'b0, ~HS_POL, ~VS_POL, 1'b0};

    state_t           state;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;

    always_ff @(posedge clk25_2 or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            x     <= '0;
            y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    x <= '0;
                    y <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (x == X_LAST) begin
                        x <= '0;
                        if (y == Y_LAST) begin
                            y <= '0;
                            if (!enable) begin
                                state <= IDLE;
                            end
                        end else begin
                            y <= y + 1'b1;
                        end
                    end else begin
                        x <= x + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    x     <= '0;
                    y     <= '0;
                end
            endcase
        end
    end

    logic [31:0] x32;
    logic [31:0] y32;
    logic        run;
    logic        act_h;
    logic        act_v;
    logic        hs_raw;
    logic        vs_raw;
    logic        vb_raw;
    logic [3:0]  dl_in;
    logic [3:0]  dl_out;

    assign x32    = 32'(x);
    assign y32    = 32'(y);
    assign run    = (state == RUN);
    assign act_h  = (x32 < X_ACT);
    assign act_v  = (y32 < Y_ACT);
    assign hs_raw = run && (x32 >= HS_BEG) && (x32 < HS_END);
    assign vs_raw = run && (y32 >= VS_BEG) && (y32 < VS_END);
    assign vb_raw = run && !act_v;

    // Stage 0 decodes only registered state/counters, so enable never
    // reaches an output combinationally.
    assign pix_req     = run && act_h && act_v;
    assign line_start  = run && (x == '0) && act_v;
    assign frame_start = run && (x == '0) && (y == '0);
    assign pix_x       = x;
    assign pix_y       = y;
    assign running     = run;

    // Polarity is applied before the delay line so the outputs come
    // straight from flops and reset to their inactive levels.
    assign dl_in = {pix_req,
                    hs_raw ? HS_POL : ~HS_POL,
                    vs_raw ? VS_POL : ~VS_POL,
                    vb_raw};

    sig_delay_line #(
        .W    (4),
        .D    (PIPE_DEPTH),
        .INIT (DL_INIT)
    ) u_delay (
        .clk25_2 (clk25_2),
        .reset_n (reset_n),
        .din     (dl_in),
        .dout    (dl_out)
    );

    assign {dvi_de, dvi_hs, dvi_vs, vblank} = dl_out;

endmodule

// File: tb/tb_dvi_timing_gen.sv
module tb_dvi_timing_gen;

    typedef enum int {
        EV_FS, EV_LS, EV_PR_R, EV_PR_F, EV_DE_R, EV_DE_F, EV_HS_A, EV_HS_I,
        EV_VS_A, EV_VS_I, EV_VB_R, EV_VB_F, EV_RUN_R, EV_RUN_F
    } ev_e;

    typedef struct {
        int  dut;
        ev_e kind;
        int  cyc;
    } sb_ent_t;

    sb_ent_t sb_q[$];
    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // VGA default instance
    logic        rst_v_n, en_v;
    logic        v_pix_req, v_frame_start, v_line_start;
    logic [11:0] v_pix_x, v_pix_y;
    logic        v_dvi_de, v_dvi_hs, v_dvi_vs, v_vblank, v_running;

    dvi_timing_gen u_vga (
        .clk25_2     (clk),
        .reset_n     (rst_v_n),
        .enable      (en_v),
        .pix_req     (v_pix_req),
        .pix_x       (v_pix_x),
        .pix_y       (v_pix_y),
        .frame_start (v_frame_start),
        .line_start  (v_line_start),
        .dvi_de      (v_dvi_de),
        .dvi_hs      (v_dvi_hs),
        .dvi_vs      (v_dvi_vs),
        .vblank      (v_vblank),
        .running     (v_running)
    );

    // Small corner instance: H_TOTAL=7, V_TOTAL=5, positive syncs, depth 3
    logic       rst_s_n, en_s;
    logic       s_pix_req, s_frame_start, s_line_start;
    logic [2:0] s_pix_x, s_pix_y;
    logic       s_dvi_de, s_dvi_hs, s_dvi_vs, s_vblank, s_running;

    dvi_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DEPTH(3), .CNT_W(3)
    ) u_small (
        .clk25_2     (clk),
        .reset_n     (rst_s_n),
        .enable      (en_s),
        .pix_req     (s_pix_req),
        .pix_x       (s_pix_x),
        .pix_y       (s_pix_y),
        .frame_start (s_frame_start),
        .line_start  (s_line_start),
        .dvi_de      (s_dvi_de),
        .dvi_hs      (s_dvi_hs),
        .dvi_vs      (s_dvi_vs),
        .vblank      (s_vblank),
        .running     (s_running)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int d, input ev_e k, input int c);
        sb_q.push_back('{dut: d, kind: k, cyc: c});
    endtask

    task automatic sb_check(input int d, input ev_e k);
        int idx;
        idx = -1;
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].dut == d && sb_q[i].kind == k) begin
                idx = i;
                break;
            end
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_event dut=%0d %s: actual cycle %0d, required none", d, k.name(), cyc);
        end else begin
            if (sb_q[idx].cyc != cyc) begin
                failures++;
                $display("FAIL event_cycle dut=%0d %s: actual cycle %0d required cycle %0d",
                         d, k.name(), cyc, sb_q[idx].cyc);
            end
            sb_q.delete(idx);
        end
    endtask

    // Monitors: turn output edges into scoreboard events.
    logic mon_v_en = 1'b0;
    logic mon_s_en = 1'b0;
    logic pv_pr, pv_de, pv_hs, pv_vs, pv_vb, pv_run;
    logic ps_pr, ps_de, ps_hs, ps_vs, ps_vb, ps_run;

    always @(negedge clk) begin
        if (mon_v_en) begin
            if (v_frame_start === 1'b1) sb_check(0, EV_FS);
            if (v_line_start === 1'b1)  sb_check(0, EV_LS);
            if (v_pix_req !== pv_pr)    sb_check(0, v_pix_req ? EV_PR_R : EV_PR_F);
            if (v_dvi_de !== pv_de)     sb_check(0, v_dvi_de ? EV_DE_R : EV_DE_F);
            if (~v_dvi_hs !== pv_hs)    sb_check(0, ~v_dvi_hs ? EV_HS_A : EV_HS_I);
            if (~v_dvi_vs !== pv_vs)    sb_check(0, ~v_dvi_vs ? EV_VS_A : EV_VS_I);
            if (v_vblank !== pv_vb)     sb_check(0, v_vblank ? EV_VB_R : EV_VB_F);
            if (v_running !== pv_run)   sb_check(0, v_running ? EV_RUN_R : EV_RUN_F);
        end
        pv_pr  <= v_pix_req;
        pv_de  <= v_dvi_de;
        pv_hs  <= ~v_dvi_hs;
        pv_vs  <= ~v_dvi_vs;
        pv_vb  <= v_vblank;
        pv_run <= v_running;
    end

    always @(negedge clk) begin
        if (mon_s_en) begin
            if (s_frame_start === 1'b1) sb_check(1, EV_FS);
            if (s_line_start === 1'b1)  sb_check(1, EV_LS);
            if (s_pix_req !== ps_pr)    sb_check(1, s_pix_req ? EV_PR_R : EV_PR_F);
            if (s_dvi_de !== ps_de)     sb_check(1, s_dvi_de ? EV_DE_R : EV_DE_F);
            if (s_dvi_hs !== ps_hs)     sb_check(1, s_dvi_hs ? EV_HS_A : EV_HS_I);
            if (s_dvi_vs !== ps_vs)     sb_check(1, s_dvi_vs ? EV_VS_A : EV_VS_I);
            if (s_vblank !== ps_vb)     sb_check(1, s_vblank ? EV_VB_R : EV_VB_F);
            if (s_running !== ps_run)   sb_check(1, s_running ? EV_RUN_R : EV_RUN_F);
        end
        ps_pr  <= s_pix_req;
        ps_de  <= s_dvi_de;
        ps_hs  <= s_dvi_hs;
        ps_vs  <= s_dvi_vs;
        ps_vb  <= s_vblank;
        ps_run <= s_running;
    end

    task automatic check_v_reset(input string tag);
        chk({tag, "_v_pix_req"}, 32'(v_pix_req), 0);
        chk({tag, "_v_frame_start"}, 32'(v_frame_start), 0);
        chk({tag, "_v_line_start"}, 32'(v_line_start), 0);
        chk({tag, "_v_pix_x"}, 32'(v_pix_x), 0);
        chk({tag, "_v_pix_y"}, 32'(v_pix_y), 0);
        chk({tag, "_v_dvi_de"}, 32'(v_dvi_de), 0);
        chk({tag, "_v_dvi_hs"}, 32'(v_dvi_hs), 1);
        chk({tag, "_v_dvi_vs"}, 32'(v_dvi_vs), 1);
        chk({tag, "_v_vblank"}, 32'(v_vblank), 0);
        chk({tag, "_v_running"}, 32'(v_running), 0);
    endtask

    int t0;
    int bad;

    initial begin
        en_v    = 1'b0;
        en_s    = 1'b0;
        rst_v_n = 1'b1;
        rst_s_n = 1'b1;
        #2;
        rst_v_n = 1'b0;
        rst_s_n = 1'b0;
        #1;
        check_v_reset("rst");
        chk("rst_s_dvi_hs", 32'(s_dvi_hs), 0);
        chk("rst_s_dvi_vs", 32'(s_dvi_vs), 0);
        chk("rst_s_dvi_de", 32'(s_dvi_de), 0);
        chk("rst_s_running", 32'(s_running), 0);

        @(negedge clk);
        @(negedge clk);
        rst_v_n  = 1'b1;
        rst_s_n  = 1'b1;
        @(negedge clk);
        mon_v_en = 1'b1;
        mon_s_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_s_pix_x", 32'(s_pix_x), 0);
        chk("idle_s_running", 32'(s_running), 0);

        // Small corner: two frames, stop cancelled in frame 0, honoured in frame 1.
        @(negedge clk);
        en_s = 1'b1;
        t0 = cyc + 1;
        push(1, EV_RUN_R, t0);
        push(1, EV_RUN_F, t0 + 70);
        for (int f = 0; f < 2; f++) begin
            int b;
            b = t0 + 35 * f;
            push(1, EV_FS, b);
            push(1, EV_VS_A, b + 24);
            push(1, EV_VS_I, b + 31);
            push(1, EV_VB_R, b + 17);
            push(1, EV_VB_F, b + 38);
            for (int l = 0; l < 2; l++) begin
                push(1, EV_LS, b + 7 * l);
                push(1, EV_PR_R, b + 7 * l);
                push(1, EV_PR_F, b + 7 * l + 4);
                push(1, EV_DE_R, b + 7 * l + 3);
                push(1, EV_DE_F, b + 7 * l + 7);
            end
            for (int l = 0; l < 5; l++) begin
                push(1, EV_HS_A, b + 7 * l + 8);
                push(1, EV_HS_I, b + 7 * l + 9);
            end
        end
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k < 70) begin
                chk("s_pix_x", 32'(s_pix_x), k % 7);
                chk("s_pix_y", 32'(s_pix_y), (k / 7) % 5);
            end else begin
                chk("s_idle_pix_x", 32'(s_pix_x), 0);
                chk("s_idle_pix_y", 32'(s_pix_y), 0);
            end
            if (k == 16) en_s = 1'b0;
            if (k == 22) en_s = 1'b1;
            if (k == 45) en_s = 1'b0;
        end

        // VGA defaults: start alignment and line timing over 3.4 lines.
        @(negedge clk);
        en_v = 1'b1;
        t0 = cyc + 1;
        push(0, EV_FS, t0);
        push(0, EV_RUN_R, t0);
        for (int l = 0; l < 4; l++) begin
            push(0, EV_LS, t0 + 800 * l);
            push(0, EV_PR_R, t0 + 800 * l);
            push(0, EV_DE_R, t0 + 800 * l + 2);
        end
        for (int l = 0; l < 3; l++) begin
            push(0, EV_PR_F, t0 + 800 * l + 640);
            push(0, EV_DE_F, t0 + 800 * l + 642);
            push(0, EV_HS_A, t0 + 800 * l + 658);
            push(0, EV_HS_I, t0 + 800 * l + 754);
        end
        @(negedge clk);
        chk("start_frame_start", 32'(v_frame_start), 1);
        chk("start_pix_req", 32'(v_pix_req), 1);
        chk("start_pix_x", 32'(v_pix_x), 0);
        chk("start_pix_y", 32'(v_pix_y), 0);
        chk("start_dvi_de", 32'(v_dvi_de), 0);
        repeat (3 * 800 + 300) @(negedge clk);
        chk("mid_pix_x", 32'(v_pix_x), 300);
        chk("mid_pix_y", 32'(v_pix_y), 3);
        chk("mid_dvi_de", 32'(v_dvi_de), 1);

        // Reset mid-line must clear everything without waiting for a clock.
        mon_v_en = 1'b0;
        #1;
        rst_v_n = 1'b0;
        en_v    = 1'b0;
        #1;
        check_v_reset("midrst");
        @(negedge clk);
        rst_v_n = 1'b1;
        @(negedge clk);
        mon_v_en = 1'b1;

        bad = 0;
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (v_dvi_hs !== 1'b1 || v_dvi_vs !== 1'b1 || v_dvi_de !== 1'b0 || v_running !== 1'b0)
                bad++;
        end
        chk("idle_10000_bad_cycles", bad, 0);

        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL pending_events: actual=%0d required=0", sb_q.size());
            foreach (sb_q[i]) begin
                if (i < 8)
                    $display("  pending dut=%0d %s cycle %0d", sb_q[i].dut, sb_q[i].kind.name(), sb_q[i].cyc);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dvi_timing_gen.md
Name: dvi_timing_gen

Overview:
- Parametrised video timing generator for the CH7301C DVI path; the next generation of the fixed 640x480 sync/DE logic.
- Horizontal and vertical timing, sync polarities and pixel-pipeline latency are all parameters.
- Issues pixel requests with (x,y) coordinates to the upstream pixel source and drives DE/HSYNC/VSYNC delayed to align with the returned pixel data.
- Adds frame-boundary start/stop control and frame/line strobes; sits between the pixel source/framebuffer and the DDR output stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, HSYNC active level (0 = active low)
VS_POL, 0, VSYNC active level (0 = active low)
PIPE_DEPTH, 2, cycles from pix_req to matching DVI outputs (>=1)
CNT_W, 12, x/y counter width

Ports:
clk25_2  in  1  pixel clock (any rate; name retained)
reset_n  in  1  asynchronous active-low reset
enable  in  1  run request; acted on only at frame boundaries
pix_req  out  1  pixel (pix_x,pix_y) wanted; data expected PIPE_DEPTH cycles later
pix_x  out  CNT_W  horizontal counter
pix_y  out  CNT_W  vertical counter
frame_start  out  1  one-cycle pulse at (0,0) while running
line_start  out  1  one-cycle pulse at x=0 on active lines
dvi_de  out  1  delayed data enable
dvi_hs  out  1  delayed HSYNC, polarity HS_POL
dvi_vs  out  1  delayed VSYNC, polarity VS_POL
vblank  out  1  delayed, high on lines >= V_ACTIVE
running  out  1  state == RUN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if either exceeds 2^CNT_W or PIPE_DEPTH < 1.
- Reset (asynchronous, immediate):
  - state IDLE, counters 0, pix_req/frame_start/line_start/dvi_de/vblank/running = 0.
  - dvi_hs = !HS_POL, dvi_vs = !VS_POL.
  - Delay line flushed to these inactive values.
- FSM IDLE:
  - Counters held at 0; strobes and pix_req low.
  - enable sampled high moves to RUN at the next edge.
- FSM RUN:
  - x increments every cycle and wraps at H_TOTAL-1 to 0.
  - y increments when x wraps and wraps at V_TOTAL-1 to 0.
  - First RUN cycle has x=y=0, frame_start=1 and pix_req=1.
  - At the frame-end cycle (x=H_TOTAL-1, y=V_TOTAL-1): if enable=0, next state is IDLE; otherwise RUN continues with no gap.
  - enable deasserted mid-frame never truncates the frame; reasserting it before frame end cancels the stop.
- Stage 0, registered counter domain, zero added latency:
  - pix_req = RUN && x<H_ACTIVE && y<V_ACTIVE.
  - line_start = RUN && x==0 && y<V_ACTIVE.
  - frame_start = RUN && x==0 && y==0.
- Stage-0 signals de, hs_raw and vs_raw:
  - de = pix_req.
  - hs_raw = H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw = V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
  - All are gated by RUN.
- These signals pass through a PIPE_DEPTH-stage shift register. dvi_hs/dvi_vs apply polarity on output.
- In IDLE the delay line keeps shifting inactive values, so an in-flight line drains fully.
- Registered outputs only; no combinational path from enable to any output.

Decomposition:
- Package dvi_timing_pkg:
  - state enum {IDLE, RUN}.
  - VGA 640x480@60 constant set (the defaults above).
  - 800x600@60 constant set: 800/40/128/88, 600/1/4/23, positive syncs.
  - h_total/v_total helper functions.
- Sub-module sig_delay_line: parametrised width/depth shift register with async reset to a parameter INIT vector. Used for {de, hs, vs, vblank}.

Test Plan:
- Reset/idle: defaults, reset_n=0 mid-line → all outputs at reset values immediately; with enable=0 after release, dvi_hs=dvi_vs=1, dvi_de=0 for 10000 cycles.
- Start alignment: enable=1 in IDLE → next cycle frame_start=1, pix_req=1, pix_x=pix_y=0; dvi_de rises exactly 2 cycles later.
- Line timing: defaults → per line 640 pix_req cycles; dvi_hs low for 96 cycles starting 656+2 cycles after line_start; line period 800.
- Frame timing: defaults → 420000 cycles between frame_start pulses; dvi_vs low for 2 lines from y=490; vblank high for 45 lines.
- Stop/restart: drop enable at y=100 → frame completes, running falls after y=524,x=799; separately, enable low then high before frame end → no gap in frame_start.
- Small corner: H 4/1/1/1, V 2/1/1/1, HS_POL=VS_POL=1, PIPE_DEPTH=3, CNT_W=3 → x wraps 0..6, y 0..4, hs high at x=5 delayed 3, frame period 35.
